// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: handshake and data bundle between the execute stage and the
// iterative RV32M multiply/divide unit. The execute/control side uses the master
// modport. The multiply/divide unit uses the slave modport.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            hold_flag_o;
  logic            busy_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;
  logic            rd_wen_o;

  modport master (
    output start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
    input  hold_flag_o, busy_o, result_o, rd_addr_o, rd_wen_o
  );

  modport slave (
    input  start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
    output hold_flag_o, busy_o, result_o, rd_addr_o, rd_wen_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit beside the execute ALU.
//
// Signed operations are computed on operand magnitudes. The sign is applied in
// the last iteration. Multiply uses shift-add. Divide uses restoring
// shift-subtract. Each CALC cycle retires UNROLL bits.
//
// Divide-by-zero and signed overflow finish on a one-cycle fast path.
//
// Optional feature macro: EX_MULDIV_FAST_MUL_EN
//   When defined, all multiplies use a combinational XLEN x XLEN multiplier and
//   complete in one cycle. When undefined, multiplies iterate like divides and
//   no hardware multiplier is inferred.
module ex_muldiv #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam int              NSTEP    = XLEN / UNROLL;
  localparam int              CNT_W    = $clog2(NSTEP + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NSTEP);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  // Two's-complement negation of one XLEN word.
  function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  // Apply the latched result sign to a magnitude.
  function automatic logic [XLEN-1:0] sign_fix_f(input logic [XLEN-1:0] x,
                                                 input logic            neg);
    return neg ? neg_f(x) : x;
  endfunction

  // Control state.
  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             wen_q;
  logic [XLEN-1:0]  res_q;
  logic [4:0]       rd_out_q;
  logic             hold;
  logic             start_ok;

  // Latched operation context and the datapath working registers.
  logic [2:0]       op_q;
  logic [4:0]       rd_q;
  logic             neg_q;
  logic [XLEN-1:0]  acc_q;    // product high half / partial remainder
  logic [XLEN-1:0]  lo_q;     // multiplier->product low half / dividend->quotient
  logic [XLEN-1:0]  mcand_q;  // multiplicand or divisor magnitude

  // Operand decode at the start edge.
  logic            is_div_i;
  logic            s1_i, s2_i;
  logic [XLEN-1:0] mag1_i, mag2_i;
  logic            neg_i;
  logic            div_zero_i, ovf_i;
  logic            fast_i;
  logic [XLEN-1:0] fast_res;

  // Iteration datapath.
  logic [XLEN-1:0] acc_n, lo_n;
  logic [XLEN:0]   rtmp, sum;
  logic [XLEN-1:0] calc_res;

  // Decode signedness and magnitudes, and detect the fast-path corner cases.
  always_comb begin
    is_div_i   = bus.op_i[2];
    s1_i       = ((bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
                  (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM)) && bus.op1_i[XLEN-1];
    s2_i       = ((bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) ||
                  (bus.op_i == OP_REM)) && bus.op2_i[XLEN-1];
    mag1_i     = sign_fix_f(bus.op1_i, s1_i);
    mag2_i     = sign_fix_f(bus.op2_i, s2_i);
    // The remainder follows the dividend sign. Other results use the XOR of the
    // operand signs. MUL keeps the low half, which needs no sign handling.
    neg_i      = (bus.op_i == OP_REM) ? s1_i : ((bus.op_i != OP_MUL) && (s1_i ^ s2_i));
    div_zero_i = is_div_i && (bus.op2_i == '0);
    ovf_i      = ((bus.op_i == OP_DIV) || (bus.op_i == OP_REM)) &&
                 (bus.op1_i == MIN_NEG) && (bus.op2_i == '1);
  end

`ifdef EX_MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] ext1_i, ext2_i, full_i;
  logic        [XLEN-1:0]   mul_res_i;

  // Single-cycle multiply on sign- or zero-extended operands.
  always_comb begin
    ext1_i    = {{XLEN{s1_i}}, bus.op1_i};
    ext2_i    = {{XLEN{s2_i}}, bus.op2_i};
    full_i    = ext1_i * ext2_i;
    mul_res_i = (bus.op_i == OP_MUL) ? full_i[XLEN-1:0] : full_i[2*XLEN-1:XLEN];
  end
`endif

  // Select the results that finish without iterating.
  always_comb begin
    fast_i   = 1'b0;
    fast_res = '0;
    if (div_zero_i) begin
      fast_i   = 1'b1;
      fast_res = bus.op_i[1] ? bus.op1_i : '1;
    end else if (ovf_i) begin
      fast_i   = 1'b1;
      fast_res = bus.op_i[1] ? '0 : bus.op1_i;
    end
`ifdef EX_MULDIV_FAST_MUL_EN
    else if (!is_div_i) begin
      fast_i   = 1'b1;
      fast_res = mul_res_i;
    end
`endif
  end

  // Perform UNROLL shift-add or restoring shift-subtract steps per cycle.
  always_comb begin
    acc_n = acc_q;
    lo_n  = lo_q;
    rtmp  = '0;
    sum   = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        rtmp = {acc_n, lo_n[XLEN-1]};
        lo_n = {lo_n[XLEN-2:0], 1'b0};
        if (rtmp >= {1'b0, mcand_q}) begin
          acc_n   = rtmp[XLEN-1:0] - mcand_q;
          lo_n[0] = 1'b1;
        end else begin
          acc_n = rtmp[XLEN-1:0];
        end
      end else begin
        sum   = {1'b0, acc_n} + (lo_n[0] ? {1'b0, mcand_q} : '0);
        acc_n = sum[XLEN:1];
        lo_n  = {sum[0], lo_n[XLEN-1:1]};
      end
    end
  end

  // Form the final result from the last step and apply the sign.
  always_comb begin
    calc_res = '0;
    case (op_q)
      OP_MUL:                        calc_res = lo_n;
      // The high half of a negated 2*XLEN product takes a carry only when the
      // low half is zero.
      OP_MULH, OP_MULHSU, OP_MULHU:  calc_res = neg_q ? (~acc_n + XLEN'(lo_n == '0)) : acc_n;
      OP_DIV, OP_DIVU:               calc_res = sign_fix_f(lo_n, neg_q);
      default:                       calc_res = sign_fix_f(acc_n, neg_q);
    endcase
  end

  // Compute the next state and the stall request. flush_i overrides everything.
  always_comb begin
    state_nxt = state_q;
    hold      = 1'b0;
    start_ok  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          start_ok  = 1'b1;
          hold      = 1'b1;
          state_nxt = fast_i ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        hold = 1'b1;
        if (cnt_q == CNT_W'(1)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.flush_i) state_nxt = S_IDLE;
  end

  // Update the state, counter and the registered result, address and enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      wen_q    <= 1'b0;
      res_q    <= '0;
      rd_out_q <= '0;
    end else begin
      state_q <= state_nxt;
      busy_q  <= (state_nxt != S_IDLE);
      wen_q   <= (state_nxt == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            cnt_q <= CNT_INIT;
            if (fast_i) begin
              res_q    <= fast_res;
              rd_out_q <= bus.rd_addr_i;
            end
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            res_q    <= calc_res;
            rd_out_q <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Capture the operation context at the start edge, then advance the datapath in CALC.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      op_q    <= bus.op_i;
      rd_q    <= bus.rd_addr_i;
      neg_q   <= neg_i;
      acc_q   <= '0;
      lo_q    <= is_div_i ? mag1_i : mag2_i;
      mcand_q <= is_div_i ? mag2_i : mag1_i;
    end else if (state_q == S_CALC) begin
      acc_q <= acc_n;
      lo_q  <= lo_n;
    end
  end

  assign bus.hold_flag_o = hold;
  assign bus.busy_o      = busy_q;
  assign bus.result_o    = res_q;
  assign bus.rd_addr_o   = rd_out_q;
  assign bus.rd_wen_o    = wen_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed testbench for ex_muldiv. Two instances run side by side.
// One uses UNROLL = 1 and the other uses UNROLL = 4. Expected results and
// latencies are hand-computed constants.
module tb_ex_muldiv;
  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

`ifdef EX_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_LAT4 = 1;
`else
  localparam int MUL_LAT  = 33;
  localparam int MUL_LAT4 = 9;
`endif
  localparam int DIV_LAT  = 33;
  localparam int DIV_LAT4 = 9;

  logic clk;
  logic rst;
  logic sel4;
  int   n_cmp = 0;
  int   n_bad = 0;

  ex_muldiv_if #(.XLEN(XLEN)) bus ();
  ex_muldiv_if #(.XLEN(XLEN)) bus4 ();

  ex_muldiv #(.XLEN(XLEN), .UNROLL(1)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  ex_muldiv #(.XLEN(XLEN), .UNROLL(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  logic        obs_wen, obs_busy, obs_hold;
  logic [31:0] obs_res;
  logic [4:0]  obs_rd;
  assign obs_wen  = sel4 ? bus4.rd_wen_o    : bus.rd_wen_o;
  assign obs_busy = sel4 ? bus4.busy_o      : bus.busy_o;
  assign obs_hold = sel4 ? bus4.hold_flag_o : bus.hold_flag_o;
  assign obs_res  = sel4 ? bus4.result_o    : bus.result_o;
  assign obs_rd   = sel4 ? bus4.rd_addr_o   : bus.rd_addr_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    if (sel4) begin
      bus4.start_i = st; bus4.op_i = op; bus4.op1_i = a; bus4.op2_i = b; bus4.rd_addr_i = rd;
    end else begin
      bus.start_i = st; bus.op_i = op; bus.op1_i = a; bus.op2_i = b; bus.rd_addr_i = rd;
    end
  endtask

  task automatic set_flush(input logic f);
    if (sel4) bus4.flush_i = f;
    else      bus.flush_i = f;
  endtask

  // Start one operation and follow it to DONE. If keep is set, start_i stays high
  // through DONE. Otherwise the inputs are scrambled right after the start edge.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int lat, input bit keep);
    int cyc;
    bit hold_ok;
    set_in(1'b1, op, a, b, rd);
    #1;
    chk({tag, "_hold_start"}, 32'(obs_hold), 32'd1);
    cyc     = 0;
    hold_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (!keep) set_in(1'b0, ~op, ~a, ~b, ~rd);
      #1;
      if (!obs_wen && !obs_hold) hold_ok = 1'b0;
    end while (!obs_wen && cyc < 100);
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk({tag, "_result"}, obs_res, exp);
    chk({tag, "_rd"}, 32'(obs_rd), 32'(rd));
    chk({tag, "_hold_calc"}, 32'(hold_ok), 32'd1);
    chk({tag, "_hold_done"}, 32'(obs_hold), 32'd0);
    chk({tag, "_busy_done"}, 32'(obs_busy), 32'd1);
    @(posedge clk);
    #1;
    if (keep) set_in(1'b0, op, a, b, rd);
    #1;
    chk({tag, "_wen_after"}, 32'(obs_wen), 32'd0);
    chk({tag, "_busy_after"}, 32'(obs_busy), 32'd0);
  endtask

  initial begin
    int pulses;
    rst  = 1'b1;
    sel4 = 1'b1;
    set_in(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    set_flush(1'b0);
    sel4 = 1'b0;
    set_in(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    set_flush(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", obs_res, 32'd0);
    chk("rst_rd", 32'(obs_rd), 32'd0);
    chk("rst_wen", 32'(obs_wen), 32'd0);
    chk("rst_busy", 32'(obs_busy), 32'd0);
    chk("rst_hold", 32'(obs_hold), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Multiply, UNROLL = 1
    do_op("mul_7_m3",       OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, MUL_LAT, 1'b0);
    do_op("mulhu_ff_ff",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, MUL_LAT, 1'b0);
    do_op("mulhsu_ff_ff",   OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, MUL_LAT, 1'b0);
    do_op("mulh_min_min",   OP_MULH,   32'h80000000, 32'h80000000, 5'd4,  32'h40000000, MUL_LAT, 1'b0);
    do_op("mulh_min_2",     OP_MULH,   32'h80000000, 32'd2,        5'd5,  32'hFFFFFFFF, MUL_LAT, 1'b0);

    // Divide, UNROLL = 1
    do_op("div_m7_2",       OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, DIV_LAT, 1'b0);
    do_op("rem_m7_2",       OP_REM,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, DIV_LAT, 1'b0);
    do_op("divu_100_7",     OP_DIVU,   32'd100,      32'd7,        5'd8,  32'd14,       DIV_LAT, 1'b0);
    do_op("remu_100_7",     OP_REMU,   32'd100,      32'd7,        5'd9,  32'd2,        DIV_LAT, 1'b0);
    do_op("div_20_m3",      OP_DIV,    32'd20,       32'hFFFFFFFD, 5'd10, 32'hFFFFFFFA, DIV_LAT, 1'b0);
    do_op("rem_20_m3",      OP_REM,    32'd20,       32'hFFFFFFFD, 5'd11, 32'd2,        DIV_LAT, 1'b0);

    // Fast paths
    do_op("divu_5_0",       OP_DIVU,   32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1, 1'b0);
    do_op("rem_5_0",        OP_REM,    32'd5,        32'd0,        5'd13, 32'd5,        1, 1'b0);
    do_op("div_m1_0",       OP_DIV,    32'hFFFFFFFF, 32'd0,        5'd14, 32'hFFFFFFFF, 1, 1'b0);
    do_op("div_ovf",        OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1, 1'b0);
    do_op("rem_ovf",        OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1, 1'b0);

    // Flush 10 cycles into a DIV
    set_in(1'b1, OP_DIV, 32'd1000, 32'd7, 5'd17);
    @(posedge clk);
    #1;
    set_in(1'b0, OP_DIV, 32'd1000, 32'd7, 5'd17);
    repeat (9) @(posedge clk);
    #1;
    set_flush(1'b1);
    #1;
    chk("flush_busy_before", 32'(obs_busy), 32'd1);
    @(posedge clk);
    #1;
    set_flush(1'b0);
    #1;
    chk("flush_busy_after", 32'(obs_busy), 32'd0);
    chk("flush_wen_after", 32'(obs_wen), 32'd0);
    chk("flush_hold_after", 32'(obs_hold), 32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (obs_wen) pulses++;
    end
    chk("flush_no_wen", 32'(pulses), 32'd0);

    do_op("mul_3_4",        OP_MUL,    32'd3,        32'd4,        5'd18, 32'd12,       MUL_LAT, 1'b0);
    do_op("divu_keep",      OP_DIVU,   32'd100,      32'd7,        5'd19, 32'd14,       DIV_LAT, 1'b1);

    // UNROLL = 4 instance
    sel4 = 1'b1;
    #1;
    do_op("u4_divu_ff_3",   OP_DIVU,   32'hFFFFFFFF, 32'd3,        5'd20, 32'h55555555, DIV_LAT4, 1'b0);
    do_op("u4_mul",         OP_MUL,    32'h12345678, 32'h10,       5'd21, 32'h23456780, MUL_LAT4, 1'b0);
    do_op("u4_rem_m7_2",    OP_REM,    32'hFFFFFFF9, 32'd2,        5'd22, 32'hFFFFFFFF, DIV_LAT4, 1'b0);

    // Reset in the middle of CALC
    set_in(1'b1, OP_DIVU, 32'hFFFFFFFF, 32'd3, 5'd23);
    @(posedge clk);
    #1;
    set_in(1'b0, OP_DIVU, 32'hFFFFFFFF, 32'd3, 5'd23);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_result", obs_res, 32'd0);
    chk("midrst_rd", 32'(obs_rd), 32'd0);
    chk("midrst_wen", 32'(obs_wen), 32'd0);
    chk("midrst_busy", 32'(obs_busy), 32'd0);
    chk("midrst_hold", 32'(obs_hold), 32'd0);
    do_op("u4_divu_after_rst", OP_DIVU, 32'd100,     32'd7,        5'd24, 32'd14,       DIV_LAT4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative RV32M multiply/divide unit that sits beside the single-cycle execute ALU. It accepts one M-extension operation and stalls the pipeline through the control block. When finished it delivers a registered result with a one-cycle write-enable toward ex_mem. Operand width and bits retired per cycle are parametrised; the divide-by-zero and signed-overflow corner cases complete on a fast path.

Parameters:
XLEN, 32, operand/result width (even, >= 8)
UNROLL, 1, bits of product/quotient resolved per cycle; legal 1, 2, 4; must divide XLEN

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start_i  input  1  M-extension op present in EX (opcode 0110011, funct7 0000001)
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op1_i  input  XLEN  rs1 value, already forwarded
op2_i  input  XLEN  rs2 value, already forwarded
rd_addr_i  input  5  destination register
flush_i  input  1  jump/kill from control; aborts the operation in flight
hold_flag_o  output  1  stall request to control
busy_o  output  1  state != IDLE
result_o  output  XLEN  result, valid while rd_wen_o = 1
rd_addr_o  output  5  destination, valid while rd_wen_o = 1
rd_wen_o  output  1  one-cycle result-valid / register write enable

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. On rst, state goes to IDLE and result_o, rd_addr_o, rd_wen_o, busy_o and the iteration counter all go to 0.
- States:
  - IDLE: accepts work.
  - CALC: iterates.
  - DONE: presents the result for one cycle, then returns to IDLE.
- IDLE with start_i = 1:
  - Latch op_i, rd_addr_i, operand magnitudes and result sign.
  - Load counter with XLEN/UNROLL.
  - Go to CALC, or directly to DONE on a fast path.
- Fast paths (DONE in the next cycle):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = op1_i.
  - Signed overflow: op1 = most-negative value and op2 = all ones, DIV or REM only. Quotient = op1_i, remainder = 0.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL takes the low XLEN bits of the product; MULH* take the high XLEN bits of the 2*XLEN product.
  - Signed operations work on magnitudes and negate at the end. Product sign = XOR of the operand signs. Quotient sign = XOR of the signs. Remainder sign = dividend sign.
- CALC: each cycle performs UNROLL shift-add (multiply) or restoring shift-subtract (divide) steps and decrements the counter. When the counter reaches 1, the cycle applies sign correction, selects the final result and goes to DONE.
- DONE: result_o and rd_addr_o are held, rd_wen_o = 1 for exactly this cycle, then IDLE. rd_wen_o = 0 in every other state.
- Latency: rd_wen_o rises XLEN/UNROLL + 1 cycles after the start edge (33 at default settings). The fast path takes 1 cycle.
- hold_flag_o is combinational:
  - 1 in IDLE when start_i = 1 and flush_i = 0.
  - 1 throughout CALC.
  - 0 in DONE, so the instruction retires that cycle.
- start_i is sampled only in IDLE. It is ignored in CALC and DONE; the same instruction is still present in EX during DONE and must not restart.
- The input values present at the start edge are used; later input changes have no effect.
- flush_i:
  - Takes priority over start_i.
  - In any state, the next state is IDLE and rd_wen_o = 0 in the next cycle.
  - Flush during DONE does not suppress that cycle's rd_wen_o.
- rst during CALC behaves like a flush and also clears the outputs.
- busy_o is registered and equals state != IDLE.

Optional Feature:
EX_MULDIV_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU use a combinational XLEN x XLEN multiplier. IDLE goes straight to DONE with the registered result; latency is 1 cycle for every multiply. Divide operations remain iterative.
- Undefined: multiplies iterate like divides, with latency XLEN/UNROLL + 1. No hardware multiplier is inferred.

Test Plan:
1. MUL, op1 = 7, op2 = 0xFFFFFFFD (-3) -> result_o = 0xFFFFFFEB; rd_wen_o after 33 cycles (UNROLL = 1, feature off); hold_flag_o = 1 from the start cycle through the last CALC cycle.
2. MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULH, 0x80000000 x 0x80000000 -> 0x40000000.
3. DIV -7 / 2 -> 0xFFFFFFFD. REM -7 % 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 % 7 -> 2.
4. DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 % 0 -> 5, both 1 cycle after start. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both 1 cycle.
5. flush_i pulsed 10 cycles into a DIV -> IDLE next cycle, no rd_wen_o. A new MUL 3 x 4 started afterwards -> 12. start_i held high through DONE -> exactly one rd_wen_o pulse.
6. UNROLL = 4: DIVU 0xFFFFFFFF / 3 -> 0x55555555 after 9 cycles. rst asserted mid-CALC -> all outputs 0 the next cycle and busy_o = 0.
